// File: rtl/fc3_pkg.sv
// Shared defaults, score type and FSM state encoding for the fc3 bias/argmax stage.
package fc3_pkg;

  localparam int NUM_NEURONS = 10;
  localparam int ACC_W       = 32;
  localparam int IDX_W       = $clog2(NUM_NEURONS);

  typedef logic signed [ACC_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } fc3_state_e;

endpackage

// File: rtl/fc3_bias_add.sv
// Single-lane signed bias adder: saturates to the W-bit signed range when FC3_SAT_EN is
// defined, otherwise wraps modulo 2^W.
module fc3_bias_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] acc,
  input  logic signed [W-1:0] bias,
  output logic signed [W-1:0] sum
);

`ifdef FC3_SAT_EN
  logic signed [W:0] wide;

  assign wide = {acc[W-1], acc} + {bias[W-1], bias};

  // Overflow shows up as disagreement between the two top bits; the MSB gives the true sign.
  always_comb begin
    sum = wide[W-1:0];
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign sum = acc + bias;
`endif

endmodule

// File: rtl/fc3_bias_argmax.sv
// Final classifier stage: captures fc3 accumulators and biases, scans one neuron per cycle and
// returns the argmax class and its biased score. Overflow mode selected by FC3_SAT_EN.
module fc3_bias_argmax
  import fc3_pkg::*;
#(
  parameter  int NUM_NEURONS = fc3_pkg::NUM_NEURONS,
  parameter  int ACC_W       = fc3_pkg::ACC_W,
  localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic [NUM_NEURONS*ACC_W-1:0] acc_data,
  input  logic [NUM_NEURONS*ACC_W-1:0] bias_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_class,
  output logic [ACC_W-1:0]             out_score
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  fc3_state_e                   state_reg, state_next;
  logic [IDX_W-1:0]             idx_reg, idx_next;
  logic [NUM_NEURONS*ACC_W-1:0] acc_reg, acc_next;
  logic [NUM_NEURONS*ACC_W-1:0] bias_reg, bias_next;
  logic signed [ACC_W-1:0]      best_score_reg, best_score_next;
  logic [IDX_W-1:0]             best_idx_reg, best_idx_next;

  logic signed [ACC_W-1:0] acc_lane  [NUM_NEURONS];
  logic signed [ACC_W-1:0] bias_lane [NUM_NEURONS];
  logic signed [ACC_W-1:0] lane_score;

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane
    assign acc_lane[gi]  = acc_reg[gi*ACC_W +: ACC_W];
    assign bias_lane[gi] = bias_reg[gi*ACC_W +: ACC_W];
  end

  // One shared adder; the scan index steers which captured lane feeds it.
  fc3_bias_add #(
    .W (ACC_W)
  ) u_bias_add (
    .acc  (acc_lane[idx_reg]),
    .bias (bias_lane[idx_reg]),
    .sum  (lane_score)
  );

  assign acc_ready = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_class = best_idx_reg;
  assign out_score = best_score_reg;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    acc_next        = acc_reg;
    bias_next       = bias_reg;
    best_score_next = best_score_reg;
    best_idx_next   = best_idx_reg;

    case (state_reg)
      IDLE: begin
        if (acc_valid) begin
          acc_next   = acc_data;
          bias_next  = bias_data;
          idx_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        // Index 0 seeds the best unconditionally; strict > keeps the lowest index on ties.
        if ((idx_reg == '0) || (lane_score > best_score_reg)) begin
          best_score_next = lane_score;
          best_idx_next   = idx_reg;
        end
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      acc_reg        <= '0;
      bias_reg       <= '0;
      best_score_reg <= '0;
      best_idx_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      acc_reg        <= acc_next;
      bias_reg       <= bias_next;
      best_score_reg <= best_score_next;
      best_idx_reg   <= best_idx_next;
    end
  end

endmodule
